// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, controller state encoding and cycle-order helper.
package traffic_pkg;
  localparam logic [3:0] C_RED    = 4'b1000;
  localparam logic [3:0] C_YELLOW = 4'b0100;
  localparam logic [3:0] C_LEFT   = 4'b0010;
  localparam logic [3:0] C_GREEN  = 4'b0001;
  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [1:0] W_RED    = 2'b10;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_NONE   = 2'b00;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    H_GRN  = 4'd1,
    H_YEL1 = 4'd2,
    H_LEFT = 4'd3,
    H_YEL2 = 4'd4,
    AR1    = 4'd5,
    V_GRN  = 4'd6,
    V_YEL1 = 4'd7,
    V_LEFT = 4'd8,
    V_YEL2 = 4'd9,
    AR2    = 4'd10,
    NIGHT  = 4'd11
  } state_t;
  function automatic state_t next_phase(state_t s);
    return s == AR2 ? H_GRN : s == NIGHT ? AR2 : state_t'(s + 4'd1);
  endfunction
endpackage

// File: rtl/traffic_ctrl_param_if.sv
// traffic_ctrl_param_if: control inputs and lamp/status outputs of the intersection controller.
interface traffic_ctrl_param_if;
  logic       start;
  logic       night_mode;
  logic       ped_req_h;
  logic       ped_req_v;
  logic [3:0] o_h_car_traffic;
  logic [3:0] o_v_car_traffic;
  logic [1:0] o_h_walker_traffic;
  logic [1:0] o_v_walker_traffic;
  logic       o_ped_pend_h;
  logic       o_ped_pend_v;
  logic [3:0] o_phase;
  modport master (
    output start, night_mode, ped_req_h, ped_req_v,
    input  o_h_car_traffic, o_v_car_traffic, o_h_walker_traffic, o_v_walker_traffic,
    input  o_ped_pend_h, o_ped_pend_v, o_phase
  );
  modport slave (
    input  start, night_mode, ped_req_h, ped_req_v,
    output o_h_car_traffic, o_v_car_traffic, o_h_walker_traffic, o_v_walker_traffic,
    output o_ped_pend_h, o_ped_pend_v, o_phase
  );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..CLK_PER_TICK-1 counter with clear, tick on terminal count.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int PW = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == PW'(CLK_PER_TICK - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + PW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: parametrised two-road controller with pedestrian gating and night flash.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CLK_PER_TICK = 50_000_000,
  parameter int TW           = 8,
  parameter int T_GREEN      = 20,
  parameter int T_YELLOW     = 2,
  parameter int T_LEFT       = 10,
  parameter int T_ALLRED     = 1,
  parameter int T_FLASH      = 6,
  parameter int PED_AUTO     = 1
) (
  input logic clk,
  input logic reset,
  traffic_ctrl_param_if.slave bus
);
  localparam logic ped_auto = PED_AUTO != 0;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, dur;
  logic blink_q, blink_d, entry_q, entry_d, serve_q, serve_d;
  logic pend_h_q, pend_h_d, pend_v_q, pend_v_d;
  logic tick, last, in_flash;
  logic [1:0] wk;
  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE || !bus.start),
    .tick (tick)
  );
  assign dur = state_q inside {H_GRN, V_GRN} ? TW'(T_GREEN)
             : state_q inside {H_YEL1, H_YEL2, V_YEL1, V_YEL2} ? TW'(T_YELLOW)
             : state_q inside {H_LEFT, V_LEFT} ? TW'(T_LEFT)
             : state_q inside {AR1, AR2} ? TW'(T_ALLRED) : TW'(1);
  assign last = tick && timer_q == dur - TW'(1);
  assign in_flash = state_q inside {H_GRN, V_GRN} && timer_q >= TW'(T_GREEN - T_FLASH);
  // pend bits are consumed on the first cycle of the green that serves them
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    blink_d  = blink_q;
    pend_h_d = bus.ped_req_h | (pend_h_q & ~(entry_q & serve_q & state_q == V_GRN));
    pend_v_d = bus.ped_req_v | (pend_v_q & ~(entry_q & serve_q & state_q == H_GRN));
    if (!bus.start) begin
      state_d  = IDLE;
      timer_d  = '0;
      blink_d  = 1'b0;
      pend_h_d = 1'b0;
      pend_v_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = H_GRN;
    end else if (state_q == NIGHT) begin
      if (tick && !bus.night_mode) state_d = AR2;
      else if (tick) blink_d = ~blink_q;
    end else if (last) begin
      state_d = (state_q inside {AR1, AR2} && bus.night_mode) ? NIGHT : next_phase(state_q);
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + TW'(1);
      blink_d = blink_q ^ in_flash;
    end
    entry_d = state_d != state_q;
    if (entry_d && state_d != IDLE) blink_d = 1'b1;
    serve_d = !entry_d ? serve_q
            : state_d == H_GRN ? ped_auto | pend_v_d
            : state_d == V_GRN ? ped_auto | pend_h_d : 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      blink_q  <= 1'b0;
      entry_q  <= 1'b0;
      serve_q  <= 1'b0;
      pend_h_q <= 1'b0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      blink_q  <= blink_d;
      entry_q  <= entry_d;
      serve_q  <= serve_d;
      pend_h_q <= pend_h_d;
      pend_v_q <= pend_v_d;
    end
  assign wk = !serve_q ? W_RED : (!in_flash || blink_q) ? W_GREEN : W_NONE;
  always_comb begin
    bus.o_h_car_traffic    = C_RED;
    bus.o_v_car_traffic    = C_RED;
    bus.o_h_walker_traffic = W_RED;
    bus.o_v_walker_traffic = W_RED;
    case (state_q)
      IDLE: begin
        bus.o_h_car_traffic    = C_NONE;
        bus.o_v_car_traffic    = C_NONE;
        bus.o_h_walker_traffic = W_NONE;
        bus.o_v_walker_traffic = W_NONE;
      end
      H_GRN: begin
        bus.o_h_car_traffic    = C_GREEN;
        bus.o_v_walker_traffic = wk;
      end
      H_YEL1, H_YEL2: bus.o_h_car_traffic = C_YELLOW;
      H_LEFT: bus.o_h_car_traffic = C_LEFT;
      V_GRN: begin
        bus.o_v_car_traffic    = C_GREEN;
        bus.o_h_walker_traffic = wk;
      end
      V_YEL1, V_YEL2: bus.o_v_car_traffic = C_YELLOW;
      V_LEFT: bus.o_v_car_traffic = C_LEFT;
      NIGHT: begin
        bus.o_h_car_traffic    = blink_q ? C_YELLOW : C_NONE;
        bus.o_v_car_traffic    = blink_q ? C_YELLOW : C_NONE;
        bus.o_h_walker_traffic = W_NONE;
        bus.o_v_walker_traffic = W_NONE;
      end
      default: ;
    endcase
  end
  assign bus.o_phase      = state_q;
  assign bus.o_ped_pend_h = pend_h_q;
  assign bus.o_ped_pend_v = pend_v_q;
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb_traffic_ctrl_param: two controllers (auto / request-gated walkers) against a cycle-counting model.
module tb_traffic_ctrl_param;
  localparam int CPT = 2, TG = 4, TY = 1, TL = 2, TA = 1, TF = 2;
  localparam int P_IDLE = 0, P_HG = 1, P_HY1 = 2, P_HL = 3, P_HY2 = 4, P_AR1 = 5;
  localparam int P_VG = 6, P_VY1 = 7, P_VL = 8, P_VY2 = 9, P_AR2 = 10, P_NIGHT = 11;

  typedef struct {int ph; int cyc; bit pend_h; bit pend_v; bit srv;} mst_t;
  typedef struct packed {
    logic [3:0] ph; logic [3:0] hc; logic [3:0] vc;
    logic [1:0] hw; logic [1:0] vw; logic pend_h; logic pend_v;
  } out_t;
  typedef struct {int k; int ph; int hc; int vc; int hw; int vw; int bhw; int bvw;} vec_t;

  logic clk = 0, rst = 1, start = 0, night = 0, rh = 0, rv = 0;
  mst_t m[2];
  int vecs = 0, errs = 0;
  vec_t tbl[16];

  always #5 clk = ~clk;

  traffic_ctrl_param_if bus_a();
  traffic_ctrl_param_if bus_b();
  assign bus_a.start = start;
  assign bus_a.night_mode = night;
  assign bus_a.ped_req_h = rh;
  assign bus_a.ped_req_v = rv;
  assign bus_b.start = start;
  assign bus_b.night_mode = night;
  assign bus_b.ped_req_h = rh;
  assign bus_b.ped_req_v = rv;

  traffic_ctrl_param #(.CLK_PER_TICK(CPT), .TW(8), .T_GREEN(TG), .T_YELLOW(TY), .T_LEFT(TL),
                       .T_ALLRED(TA), .T_FLASH(TF), .PED_AUTO(1)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  traffic_ctrl_param #(.CLK_PER_TICK(CPT), .TW(8), .T_GREEN(TG), .T_YELLOW(TY), .T_LEFT(TL),
                       .T_ALLRED(TA), .T_FLASH(TF), .PED_AUTO(0)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  function automatic int plen(int p);
    int t;
    t = (p == P_HG || p == P_VG) ? TG : (p == P_HY1 || p == P_HY2 || p == P_VY1 || p == P_VY2) ? TY
      : (p == P_HL || p == P_VL) ? TL : (p == P_AR1 || p == P_AR2) ? TA : 1;
    return t * CPT;
  endfunction

  function automatic mst_t minit();
    mst_t s;
    s.ph = P_IDLE; s.cyc = 0; s.pend_h = 0; s.pend_v = 0; s.srv = 0;
    return s;
  endfunction

  function automatic mst_t mnext(mst_t s, bit autop);
    mst_t n;
    n = s;
    if (!start) return minit();
    n.pend_h = rh | (s.pend_h & !(s.ph == P_VG && s.cyc == 0 && s.srv));
    n.pend_v = rv | (s.pend_v & !(s.ph == P_HG && s.cyc == 0 && s.srv));
    if (s.ph == P_IDLE) begin
      n.ph = P_HG; n.cyc = 0;
    end else if (s.ph == P_NIGHT) begin
      if (s.cyc % CPT == CPT - 1 && !night) begin n.ph = P_AR2; n.cyc = 0; end
      else n.cyc = s.cyc + 1;
    end else if (s.cyc == plen(s.ph) - 1) begin
      n.cyc = 0;
      n.ph = ((s.ph == P_AR1 || s.ph == P_AR2) && night) ? P_NIGHT : (s.ph == P_AR2) ? P_HG : s.ph + 1;
    end else n.cyc = s.cyc + 1;
    if (n.ph != s.ph)
      n.srv = n.ph == P_HG ? (autop | n.pend_v) : n.ph == P_VG ? (autop | n.pend_h) : 1'b0;
    return n;
  endfunction

  function automatic logic [3:0] car(int p, bit h);
    int g, y1, l, y2;
    g = h ? P_HG : P_VG; y1 = h ? P_HY1 : P_VY1; l = h ? P_HL : P_VL; y2 = h ? P_HY2 : P_VY2;
    return p == g ? 4'b0001 : (p == y1 || p == y2) ? 4'b0100 : p == l ? 4'b0010 : 4'b1000;
  endfunction

  function automatic out_t mexp(mst_t s);
    out_t o;
    int t;
    logic [1:0] wk;
    o = '0;
    t = s.cyc / CPT;
    wk = !s.srv ? 2'b10 : (t < TG - TF || (t - (TG - TF)) % 2 == 0) ? 2'b01 : 2'b00;
    o.ph = 4'(s.ph); o.pend_h = s.pend_h; o.pend_v = s.pend_v;
    if (s.ph == P_NIGHT) begin
      o.hc = (t % 2 == 0) ? 4'b0100 : 4'b0000;
      o.vc = o.hc;
    end else if (s.ph != P_IDLE) begin
      o.hc = car(s.ph, 1'b1);
      o.vc = car(s.ph, 1'b0);
      o.hw = s.ph == P_VG ? wk : 2'b10;
      o.vw = s.ph == P_HG ? wk : 2'b10;
    end
    return o;
  endfunction

  function automatic out_t grab_a();
    return {bus_a.o_phase, bus_a.o_h_car_traffic, bus_a.o_v_car_traffic, bus_a.o_h_walker_traffic,
            bus_a.o_v_walker_traffic, bus_a.o_ped_pend_h, bus_a.o_ped_pend_v};
  endfunction

  function automatic out_t grab_b();
    return {bus_b.o_phase, bus_b.o_h_car_traffic, bus_b.o_v_car_traffic, bus_b.o_h_walker_traffic,
            bus_b.o_v_walker_traffic, bus_b.o_ped_pend_h, bus_b.o_ped_pend_v};
  endfunction

  task automatic cmp(input string nm, input out_t act, input out_t exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t: got ph=%0d h=%b v=%b hw=%b vw=%b pend=%b%b, want ph=%0d h=%b v=%b hw=%b vw=%b pend=%b%b",
               nm, $time, act.ph, act.hc, act.vc, act.hw, act.vw, act.pend_h, act.pend_v,
               exp.ph, exp.hc, exp.vc, exp.hw, exp.vw, exp.pend_h, exp.pend_v);
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s t=%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin m[0] = minit(); m[1] = minit(); end
    else begin m[0] = mnext(m[0], 1'b1); m[1] = mnext(m[1], 1'b0); end
    @(negedge clk);
    cmp("model_a", grab_a(), mexp(m[0]));
    cmp("model_b", grab_b(), mexp(m[1]));
  endtask

  task automatic wait_ph(input int p, input string nm);
    int n;
    n = 0;
    while (int'(bus_b.o_phase) != p && n < 200) begin step(); n++; end
    chk_v(nm, int'(bus_b.o_phase), p);
  endtask

  initial begin
    tbl[0]  = '{0,  1, 1, 8, 2, 1, 2, 2};
    tbl[1]  = '{3,  1, 1, 8, 2, 1, 2, 2};
    tbl[2]  = '{4,  1, 1, 8, 2, 1, 2, 2};
    tbl[3]  = '{6,  1, 1, 8, 2, 0, 2, 2};
    tbl[4]  = '{7,  1, 1, 8, 2, 0, 2, 2};
    tbl[5]  = '{8,  2, 4, 8, 2, 2, 2, 2};
    tbl[6]  = '{10, 3, 2, 8, 2, 2, 2, 2};
    tbl[7]  = '{14, 4, 4, 8, 2, 2, 2, 2};
    tbl[8]  = '{16, 5, 8, 8, 2, 2, 2, 2};
    tbl[9]  = '{18, 6, 8, 1, 1, 2, 2, 2};
    tbl[10] = '{23, 6, 8, 1, 1, 2, 2, 2};
    tbl[11] = '{24, 6, 8, 1, 0, 2, 2, 2};
    tbl[12] = '{26, 7, 8, 4, 2, 2, 2, 2};
    tbl[13] = '{28, 8, 8, 2, 2, 2, 2, 2};
    tbl[14] = '{32, 9, 8, 4, 2, 2, 2, 2};
    tbl[15] = '{34, 10, 8, 8, 2, 2, 2, 2};
    m[0] = minit(); m[1] = minit();
    repeat (2) @(negedge clk);
    cmp("reset_a", grab_a(), '0);
    cmp("reset_b", grab_b(), '0);
    rst = 0; start = 1;
    begin
      int cur;
      cur = -1;
      for (int i = 0; i < 16; i++) begin
        while (cur < tbl[i].k) begin step(); cur++; end
        chk_v($sformatf("tbl%0d_a", i), {bus_a.o_phase, bus_a.o_h_car_traffic, bus_a.o_v_car_traffic,
              bus_a.o_h_walker_traffic, bus_a.o_v_walker_traffic},
              (tbl[i].ph << 12) | (tbl[i].hc << 8) | (tbl[i].vc << 4) | (tbl[i].hw << 2) | tbl[i].vw);
        chk_v($sformatf("tbl%0d_b", i), {bus_b.o_phase, bus_b.o_h_car_traffic, bus_b.o_v_car_traffic,
              bus_b.o_h_walker_traffic, bus_b.o_v_walker_traffic},
              (tbl[i].ph << 12) | (tbl[i].hc << 8) | (tbl[i].vc << 4) | (tbl[i].bhw << 2) | tbl[i].bvw);
      end
    end
    // latched request on the gated controller
    wait_ph(P_HL, "wait_hleft");
    rh = 1; step(); rh = 0;
    chk_v("pend_h_set", bus_b.o_ped_pend_h, 1);
    wait_ph(P_VG, "wait_vgrn");
    chk_v("h_walk_served", bus_b.o_h_walker_traffic, 2'b01);
    step();
    chk_v("pend_h_clear", bus_b.o_ped_pend_h, 0);
    // night mode entry, blink and exit through all-red
    wait_ph(P_VL, "wait_vleft");
    night = 1;
    wait_ph(P_NIGHT, "wait_night");
    chk_v("night_yel", bus_b.o_h_car_traffic, 4'b0100);
    step(); step();
    chk_v("night_dark", bus_b.o_v_car_traffic, 4'b0000);
    night = 0;
    wait_ph(P_AR2, "wait_ar2");
    step();
    chk_v("ar2_second", bus_b.o_phase, P_AR2);
    step();
    chk_v("ar2_to_hg", bus_b.o_phase, P_HG);
    // start low mid V_GRN clears everything, restart gives a full green
    wait_ph(P_VG, "wait_vgrn2");
    step(); step();
    rh = 1; step(); rh = 0;
    chk_v("pend_before_stop", bus_b.o_ped_pend_h, 1);
    start = 0; step();
    chk_v("stop_idle", bus_b.o_phase, P_IDLE);
    chk_v("stop_pend", bus_b.o_ped_pend_h, 0);
    chk_v("stop_dark", bus_a.o_h_car_traffic, 0);
    start = 1; step();
    for (int j = 0; j < 8; j++) begin
      chk_v($sformatf("restart_hg%0d", j), bus_a.o_phase, P_HG);
      step();
    end
    chk_v("restart_hy1", bus_a.o_phase, P_HY1);
    // asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1;
    #1;
    cmp("async_rst_a", grab_a(), '0);
    cmp("async_rst_b", grab_b(), '0);
    m[0] = minit(); m[1] = minit();
    @(negedge clk);
    rst = 0;
    step();
    chk_v("post_rst_hg", bus_a.o_phase, P_HG);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 199) != 0;
      if ($urandom_range(0, 39) == 0) night = ~night;
      rh = $urandom_range(0, 9) == 0;
      rv = $urandom_range(0, 9) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
